// File: rtl/sreg_file_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional write-through bypass, optional hardwired zero register, busy scoreboard.
module sreg_file_param #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      regWE,
    input  logic [$clog2(NREGS)-1:0]  wAddr,
    input  logic [WIDTH-1:0]          wData,
    input  logic [$clog2(NREGS)-1:0]  rAddr1,
    input  logic [$clog2(NREGS)-1:0]  rAddr2,
    output logic [WIDTH-1:0]          rData1,
    output logic [WIDTH-1:0]          rData2,
    input  logic                      resv,
    input  logic [$clog2(NREGS)-1:0]  resvAddr,
    output logic                      busy1,
    output logic                      busy2,
    output logic [NREGS-1:0]          busyVec,
    output logic                      wErr
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] wr_hot;
    logic [NREGS-1:0] resv_hot;
    logic [NREGS-1:0] busy_next;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             rbusy1;
    logic             rbusy2;
    logic             wbusy;
    logic             w_err_next;
    logic             byp1;
    logic             byp2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic writable(input logic [AW-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // One-hot decodes; non-writable addresses never produce a hot bit.
    always_comb begin
        wr_hot   = '0;
        resv_hot = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            wr_hot[i]   = regWE && (wAddr == AW'(i)) && writable(AW'(i));
            resv_hot[i] = resv && (resvAddr == AW'(i)) && writable(AW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_hot[i]) begin
                    regs[i] <= wData;
                end
            end
        end
    end

    // A reservation outranks a landing write so the newest producer keeps the register busy.
    always_comb begin
        busy_next = busyVec;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (resv_hot[i]) begin
                busy_next[i] = 1'b1;
            end else if (wr_hot[i]) begin
                busy_next[i] = 1'b0;
            end
        end
    end

    // Read and busy muxes; out-of-range addresses fall through to zero.
    always_comb begin
        rd1    = '0;
        rd2    = '0;
        rbusy1 = 1'b0;
        rbusy2 = 1'b0;
        wbusy  = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rAddr1 == AW'(i)) begin
                rd1    = regs[i];
                rbusy1 = busyVec[i];
            end
            if (rAddr2 == AW'(i)) begin
                rd2    = regs[i];
                rbusy2 = busyVec[i];
            end
            if (wAddr == AW'(i)) begin
                wbusy = busyVec[i];
            end
        end
        if ((ZERO_REG != 0) && (rAddr1 == '0)) begin
            rd1 = '0;
        end
        if ((ZERO_REG != 0) && (rAddr2 == '0)) begin
            rd2 = '0;
        end
    end

    always_comb begin
        byp1 = (BYPASS != 0) && regWE && (wAddr == rAddr1) && writable(wAddr);
        byp2 = (BYPASS != 0) && regWE && (wAddr == rAddr2) && writable(wAddr);
    end

    always_comb begin
        rData1 = '0;
        rData2 = '0;
        if (!reset) begin
            rData1 = byp1 ? wData : rd1;
            rData2 = byp2 ? wData : rd2;
        end
        busy1 = rbusy1 && !reset;
        busy2 = rbusy2 && !reset;
    end

    always_comb begin
        w_err_next = regWE && (!writable(wAddr) || !wbusy);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busyVec <= '0;
            wErr    <= 1'b0;
        end else begin
            busyVec <= busy_next;
            wErr    <= w_err_next;
        end
    end

endmodule
